// File: rtl/toggle_arbiter.sv
// Round-robin arbiter: each grant commits one toggle of the requester's own bit in a shared bank.
// Define TOGGLE_ARB_STATS_EN to add the saturating commit counter port grant_cnt.
module toggle_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         done,
  output logic         busy,
  output logic [N-1:0] q,
  output logic [N-1:0] a
`ifdef TOGGLE_ARB_STATS_EN
  ,
  output logic [7:0]   grant_cnt
`endif
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] ptr, ptr_d, pick;
  logic [N-1:0]  gnt_d, q_d, a_d;
  logic          done_d, busy_d;
`ifdef TOGGLE_ARB_STATS_EN
  logic [CW-1:0] cnt_d;
`endif

  // First set request bit at or above p, wrapping past N-1.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] sel;
    logic          hit;
    int unsigned   cand;
    sel = p;
    hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(p) + i) % N;
      if (!hit && r[PW'(cand)]) begin
        sel = PW'(cand);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] k);
    return (k == PW'(N - 1)) ? '0 : k + PW'(1);
  endfunction

  // Next-state and next-output decode.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    gnt_d   = gnt;
    q_d     = q;
    a_d     = a;
    done_d  = 1'b0;
`ifdef TOGGLE_ARB_STATS_EN
    cnt_d   = grant_cnt;
`endif
    pick    = rr_pick(req, ptr);

    case (state)
      IDLE: begin
        if (|req) begin
          gnt_d   = N'(1) << pick;
          ptr_d   = ptr_after(pick);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Mask form keeps a[k] tied to the pre-toggle q[k] regardless of ordering.
        q_d     = q ^ gnt;
        a_d     = (a & ~gnt) | (~q & gnt);
        done_d  = 1'b1;
        state_d = WAIT;
`ifdef TOGGLE_ARB_STATS_EN
        cnt_d   = (grant_cnt == 8'hFF) ? grant_cnt : grant_cnt + 8'd1;
`endif
      end
      WAIT: begin
        if ((req & gnt) == '0) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any pending commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      q     <= '0;
      a     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
`ifdef TOGGLE_ARB_STATS_EN
      grant_cnt <= '0;
`endif
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      gnt   <= gnt_d;
      q     <= q_d;
      a     <= a_d;
      done  <= done_d;
      busy  <= busy_d;
`ifdef TOGGLE_ARB_STATS_EN
      grant_cnt <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_toggle_arbiter.sv
// Bench for toggle_arbiter: directed vector table, corner sequences and random traffic vs a model.
// Honours TOGGLE_ARB_STATS_EN for the grant counter checks.
module tb_toggle_arbiter;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         done;
  logic         busy;
  logic [N-1:0] q;
  logic [N-1:0] a;
`ifdef TOGGLE_ARB_STATS_EN
  logic [7:0]   grant_cnt;
`endif

  toggle_arbiter #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .q    (q),
    .a    (a)
`ifdef TOGGLE_ARB_STATS_EN
    ,.grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: who owns the bank, cycles since grant, next search start.
  int m_owner = -1;
  int m_age   = 0;
  int m_ptr   = 0;
  int m_q     = 0;
  int m_a     = 0;
  int m_done  = 0;
  int m_cnt   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model_step(input logic r, input logic [N-1:0] rq);
    int rqi;
    int idx;
    rqi    = 32'(rq);
    m_done = 0;
    if (r) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_q = 0; m_a = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < int'(N); i++) begin
        idx = (m_ptr + i) % int'(N);
        if (m_owner < 0 && ((rqi >> idx) & 1) == 1) m_owner = idx;
      end
      if (m_owner >= 0) begin
        m_age = 0;
        m_ptr = (m_owner + 1) % int'(N);
      end
    end else if (m_age == 0) begin
      if (((m_q >> m_owner) & 1) == 1) m_a = m_a & ~(1 << m_owner);
      else                             m_a = m_a | (1 << m_owner);
      m_q    = m_q ^ (1 << m_owner);
      m_done = 1;
      m_age  = 1;
      if (m_cnt < 255) m_cnt++;
    end else if (((rqi >> m_owner) & 1) == 0) begin
      m_owner = -1;
    end
  endfunction

  // One clock: drive inputs, step the model on the edge, sample #1 later.
  task automatic tick(input logic r, input logic [N-1:0] rq);
    rst = r;
    req = rq;
    @(posedge clk);
    model_step(r, rq);
    #1;
    chk("onehot_gnt", $onehot0(gnt) ? 1 : 0, 1);
    chk("model_gnt",  32'(gnt),  (m_owner < 0) ? 0 : (1 << m_owner));
    chk("model_done", 32'(done), m_done);
    chk("model_busy", 32'(busy), (m_owner >= 0) ? 1 : 0);
    chk("model_q",    32'(q),    m_q);
    chk("model_a",    32'(a),    m_a);
`ifdef TOGGLE_ARB_STATS_EN
    chk("model_cnt",  32'(grant_cnt), m_cnt);
`endif
  endtask

  typedef struct packed {
    logic       r;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       done;
    logic       busy;
    logic [3:0] q;
    logic [3:0] a;
  } vec_t;

  vec_t vecs[15];
  int   ord[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rq;
    int           ngr;
    int           g;
    int           pg;
    logic         r;

    rst = 1'b1;
    req = '0;

    //            r     req      gnt      done  busy  q        a
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0001};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001};
    vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 1'b1, 4'b0001, 4'b0001};
    vecs[6]  = '{1'b0, 4'b0000, 4'b0100, 1'b1, 1'b1, 4'b0101, 4'b0101};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b0101};
    vecs[8]  = '{1'b0, 4'b1001, 4'b1000, 1'b0, 1'b1, 4'b0101, 4'b0101};
    vecs[9]  = '{1'b0, 4'b1001, 4'b1000, 1'b1, 1'b1, 4'b1101, 4'b1101};
    vecs[10] = '{1'b0, 4'b1001, 4'b1000, 1'b0, 1'b1, 4'b1101, 4'b1101};
    vecs[11] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b1101};
    vecs[12] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b1101, 4'b1101};
    vecs[13] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 4'b1100, 4'b1100};
    vecs[14] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1100, 4'b1100};

    for (int i = 0; i < 15; i++) begin
      tick(vecs[i].r, vecs[i].req);
      chk($sformatf("vec%0d_gnt", i),  32'(gnt),  32'(vecs[i].gnt));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_q", i),    32'(q),    32'(vecs[i].q));
      chk($sformatf("vec%0d_a", i),    32'(a),    32'(vecs[i].a));
    end

    // Reset landing in the GRANT cycle drops the commit and clears the pointer.
    tick(1'b1, 4'b0000);
    tick(1'b0, 4'b0010);
    chk("rstgrant_pre_gnt", 32'(gnt), 32'h2);
    tick(1'b1, 4'b0010);
    chk("rstgrant_gnt",  32'(gnt),  0);
    chk("rstgrant_q",    32'(q),    0);
    chk("rstgrant_a",    32'(a),    0);
    chk("rstgrant_done", 32'(done), 0);
    tick(1'b0, 4'b0000);
    chk("rstgrant_nodone", 32'(done), 0);
    chk("rstgrant_q2",     32'(q),    0);
    tick(1'b0, 4'b1111);
    chk("rstgrant_ptr0", 32'(gnt), 32'h1);

    // All requesters asking, each dropping only while granted: strict rotation.
    tick(1'b1, 4'b0000);
    rq  = 4'hF;
    ngr = 0;
    pg  = 0;
    for (int c = 0; c < 40 && ngr < 5; c++) begin
      tick(1'b0, rq);
      g = 32'(gnt);
      if (g != 0 && pg == 0) begin
        for (int b = 0; b < int'(N); b++) if (g == (1 << b)) ord[ngr] = b;
        ngr++;
      end
      pg = g;
      rq = 4'hF & ~gnt;
    end
    chk("rr_grants", ngr, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), ord[i], i % 4);
    chk("rr_q_before", 32'(q), 32'hF);
    tick(1'b0, 4'hF & ~gnt);
    chk("rr_q_after", 32'(q), 32'hE);
    chk("rr_a_after", 32'(a), 32'hE);

    // Random traffic, including occasional resets, against the model.
    tick(1'b1, 4'b0000);
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0:       rq = 4'($urandom);
        1:       rq = rq & ~gnt;
        default: rq = rq;
      endcase
      tick(r, rq);
    end

`ifdef TOGGLE_ARB_STATS_EN
    // Counter saturation after 300 commits.
    tick(1'b1, 4'b0000);
    for (int c = 0; c < 300; c++) begin
      tick(1'b0, 4'b0010);
      tick(1'b0, 4'b0000);
      tick(1'b0, 4'b0000);
    end
    chk("cnt_saturated", 32'(grant_cnt), 255);
    tick(1'b0, 4'b0000);
    chk("cnt_hold", 32'(grant_cnt), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
